// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit lab CPU controller: opcodes, sequencer
// states and instruction-field helpers.
package cpu_pkg;

    localparam int REG_IDX_W = 2;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_NAND = 4'd3;
    localparam logic [3:0] OP_SHL  = 4'd4;
    localparam logic [3:0] OP_SHR  = 4'd5;
    localparam logic [3:0] OP_OUT  = 4'd6;
    localparam logic [3:0] OP_IN   = 4'd7;
    localparam logic [3:0] OP_MOV  = 4'd8;
    localparam logic [3:0] OP_JMP  = 4'd9;
    localparam logic [3:0] OP_JZ   = 4'd10;
    localparam logic [3:0] OP_JC   = 4'd11;
    localparam logic [3:0] OP_HLT  = 4'd15;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        IMM,
        BRANCH,
        WAIT_IN,
        EXEC,
        HALT
    } state_e;

    localparam int IR_OP_LSB = 4;
    localparam int IR_A_LSB  = 2;
    localparam int IR_B_LSB  = 0;

    function automatic logic [3:0] ir_op(input logic [7:0] ir);
        return ir[IR_OP_LSB +: 4];
    endfunction

    function automatic logic [REG_IDX_W-1:0] ir_a(input logic [7:0] ir);
        return ir[IR_A_LSB +: REG_IDX_W];
    endfunction

    function automatic logic [REG_IDX_W-1:0] ir_b(input logic [7:0] ir);
        return ir[IR_B_LSB +: REG_IDX_W];
    endfunction

    // Only true ALU operations update the flags; MOV and IN pass data through.
    function automatic logic sets_flags(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_NAND) ||
               (op == OP_SHL) || (op == OP_SHR);
    endfunction

    function automatic logic writes_reg(input logic [3:0] op);
        return sets_flags(op) || (op == OP_IN) || (op == OP_MOV);
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// General register file: two combinational read ports, one synchronous write
// port, cleared asynchronously by reset_n.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int NREG = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [REG_IDX_W-1:0] rd_a_idx_i,
    input  logic [REG_IDX_W-1:0] rd_b_idx_i,
    output logic [7:0]           rd_a_data_o,
    output logic [7:0]           rd_b_data_o,
    input  logic                 wr_en_i,
    input  logic [REG_IDX_W-1:0] wr_idx_i,
    input  logic [7:0]           wr_data_i
);

    logic [7:0] regs_q [NREG];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en_i) begin
            regs_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_a_data_o = regs_q[rd_a_idx_i];
    assign rd_b_data_o = regs_q[rd_b_idx_i];

endmodule

// File: rtl/cpu_ctrl.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit lab CPU.
// Define PERF_CNT_EN to add the cyc_cnt/ret_cnt performance counters.
module cpu_ctrl
    import cpu_pkg::*;
#(
    parameter int PC_W = 8,
    parameter int NREG = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    output logic [PC_W-1:0] imem_addr,
    input  logic [7:0]      imem_data,
    output logic [7:0]      ra,
    output logic [7:0]      rb,
    output logic [3:0]      op,
    input  logic [9:0]      alu_out,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [7:0]      out_data,
    output logic            out_valid,
    output logic            zf,
    output logic            cf,
`ifdef PERF_CNT_EN
    output logic [15:0]     cyc_cnt,
    output logic [15:0]     ret_cnt,
`endif
    output logic            halted
);

    state_e          state_q;
    logic [PC_W-1:0] pc_q;
    logic [7:0]      ir_q;
    logic [7:0]      ra_q;
    logic [7:0]      rb_q;
    logic [3:0]      op_q;
    logic [7:0]      out_data_q;
    logic            out_valid_q;
    logic            in_ready_q;
    logic            zf_q;
    logic            cf_q;
    logic            halted_q;

    logic [7:0]           dec_ir_d;
    logic [3:0]           ir_opc;
    logic [3:0]           dec_opc;
    logic [REG_IDX_W-1:0] rd_a_idx;
    logic [REG_IDX_W-1:0] rd_b_idx;
    logic [7:0]           rd_a_data;
    logic [7:0]           rd_b_data;
    logic                 wb_en;
    logic                 br_taken;

    // Operands are read while the instruction is still on imem_data in DECODE,
    // so they can be registered onto ra/rb for the EXEC cycle.
    assign dec_ir_d = (state_q == DECODE) ? imem_data : ir_q;
    assign rd_a_idx = ir_a(dec_ir_d);
    assign rd_b_idx = ir_b(dec_ir_d);
    assign ir_opc   = ir_op(ir_q);
    assign dec_opc  = ir_op(imem_data);
    assign wb_en    = (state_q == EXEC) && writes_reg(ir_opc);
    assign br_taken = (ir_opc == OP_JMP) ||
                      ((ir_opc == OP_JZ) && zf_q) ||
                      ((ir_opc == OP_JC) && cf_q);

    cpu_regfile #(
        .NREG(NREG)
    ) u_regfile (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_a_idx_i (rd_a_idx),
        .rd_b_idx_i (rd_b_idx),
        .rd_a_data_o(rd_a_data),
        .rd_b_data_o(rd_b_data),
        .wr_en_i    (wb_en),
        .wr_idx_i   (ir_a(ir_q)),
        .wr_data_i  (alu_out[7:0])
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            pc_q        <= '0;
            ir_q        <= 8'h00;
            ra_q        <= 8'h00;
            rb_q        <= 8'h00;
            op_q        <= OP_NOP;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            zf_q        <= 1'b0;
            cf_q        <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            // ALU inputs idle at a NOP outside EXEC; out_valid is a strobe.
            ra_q        <= 8'h00;
            rb_q        <= 8'h00;
            op_q        <= OP_NOP;
            out_valid_q <= 1'b0;
            case (state_q)
                FETCH: begin
                    state_q <= DECODE;
                end
                DECODE: begin
                    ir_q <= imem_data;
                    pc_q <= pc_q + PC_W'(1);
                    case (dec_opc)
                        OP_JMP, OP_JZ, OP_JC: state_q <= IMM;
                        OP_IN: begin
                            state_q    <= WAIT_IN;
                            in_ready_q <= 1'b1;
                        end
                        OP_HLT: begin
                            state_q  <= HALT;
                            halted_q <= 1'b1;
                        end
                        default: begin
                            state_q <= EXEC;
                            ra_q    <= rd_a_data;
                            rb_q    <= rd_b_data;
                            op_q    <= dec_opc;
                        end
                    endcase
                end
                IMM: begin
                    state_q <= BRANCH;
                end
                BRANCH: begin
                    pc_q    <= br_taken ? PC_W'(imem_data) : pc_q + PC_W'(1);
                    state_q <= FETCH;
                end
                WAIT_IN: begin
                    // rb_q doubles as the input buffer for the IN writeback.
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        ra_q       <= rd_a_data;
                        rb_q       <= in_data;
                        op_q       <= OP_IN;
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    if (sets_flags(ir_opc)) begin
                        zf_q <= alu_out[9];
                        cf_q <= alu_out[8];
                    end
                    if (ir_opc == OP_OUT) begin
                        out_data_q  <= ra_q;
                        out_valid_q <= 1'b1;
                    end
                    state_q <= FETCH;
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign imem_addr = pc_q;
    assign ra        = ra_q;
    assign rb        = rb_q;
    assign op        = op_q;
    assign in_ready  = in_ready_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign zf        = zf_q;
    assign cf        = cf_q;
    assign halted    = halted_q;

`ifdef PERF_CNT_EN
    logic [15:0] cyc_cnt_q;
    logic [15:0] ret_cnt_q;

    // EXEC and BRANCH always last one cycle, so occupancy equals retirement.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_cnt_q <= 16'h0000;
            ret_cnt_q <= 16'h0000;
        end else begin
            if (!halted_q) begin
                cyc_cnt_q <= cyc_cnt_q + 16'd1;
            end
            if ((state_q == EXEC) || (state_q == BRANCH)) begin
                ret_cnt_q <= ret_cnt_q + 16'd1;
            end
        end
    end

    assign cyc_cnt = cyc_cnt_q;
    assign ret_cnt = ret_cnt_q;
`else
    // No counter state in this build; the sequencer above is unchanged.
`endif

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Multi-cycle fetch/decode/execute sequencer for the 8-bit lab CPU, directly upstream of the ALU.
- Fetches 8-bit instructions from a synchronous instruction memory and holds a 4x8 register file.
- Drives the ALU operand/opcode inputs (ra, rb, op) and consumes the 10-bit ALU result {zero, carry, data[7:0]} for writeback and flags.
- Handles branches, the IN/OUT port handshakes, and HALT.

Parameters:
PC_W, 8, program-counter / instruction-memory address width (wraps modulo 2^PC_W)
NREG, 4, number of 8-bit general registers (index width 2, fixed by the instruction format)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
imem_addr  out  PC_W  instruction memory address; read data valid the following cycle
imem_data  in  8  instruction memory read data
ra  out  8  ALU operand A
rb  out  8  ALU operand B
op  out  4  ALU opcode
alu_out  in  10  ALU result: [9]=zero, [8]=carry/borrow, [7:0]=data
in_data  in  8  input-port data
in_valid  in  1  input-port data valid
in_ready  out  1  controller waiting for input
out_data  out  8  output-port data
out_valid  out  1  one-cycle strobe, out_data valid
zf  out  1  zero flag
cf  out  1  carry flag
halted  out  1  HLT executed

Behaviour:
- Instruction format: ir[7:4]=opcode, ir[3:2]=dest/A register index (a), ir[1:0]=B register index (b).
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 NAND, 4 SHL, 5 SHR
  - 6 OUT, 7 IN, 8 MOV
  - 9 JMP, 10 JZ, 11 JC
  - 12-14 treated as NOP
  - 15 HLT
- Reset (async, reset_n low): state=FETCH; pc=0; all registers=0; zf=cf=0; ra=rb=0; op=0; out_data=0; out_valid=0; in_ready=0; halted=0.
- imem_addr is combinational: pc in FETCH and IMM, otherwise pc.
- States and transitions:
  - FETCH: present pc, then go to DECODE.
  - DECODE: ir<=imem_data; pc<=pc+1.
    - Opcode 9-11 -> IMM.
    - Opcode 7 -> WAIT_IN.
    - Opcode 15 -> HALT.
    - Otherwise -> EXEC.
  - IMM: present pc (address of target byte), then go to BRANCH.
  - BRANCH: target=imem_data.
    - pc<=target if JMP, or JZ with zf=1, or JC with cf=1; otherwise pc<=pc+1 (skip target byte).
    - Then go to FETCH.
  - WAIT_IN: in_ready=1. On in_valid=1, latch in_data into inbuf and go to EXEC. No timeout; waits indefinitely.
  - EXEC: ra=reg[a]; rb=(opcode 7) ? inbuf : reg[b]; op=opcode.
    - Opcodes 1-5, 7, 8: reg[a]<=alu_out[7:0] at end of the cycle.
    - Opcodes 1-5 only: zf<=alu_out[9], cf<=alu_out[8]. MOV and IN leave flags unchanged.
    - Opcode 6: out_data<=reg[a]; out_valid=1 for the next cycle only.
    - NOP: no write.
    - Then go to FETCH.
  - HALT: halted=1; absorbing state until reset.
- ra, rb and op are 0 in every state except EXEC, so the ALU sees a NOP.
- Latency:
  - ALU/MOV/OUT/NOP: 3 cycles.
  - Branch: 4 cycles.
  - IN: 3 cycles + wait time.
- pc wraps 255->0, including during the target-byte fetch.
- SUB: cf holds the ALU borrow bit exactly as delivered. The controller performs no arithmetic on alu_out.
- Reset asserted mid-instruction aborts it; no partial writeback.

Optional Feature:
PERF_CNT_EN
- Defined: adds outputs cyc_cnt[15:0] and ret_cnt[15:0], both reset to 0.
  - cyc_cnt increments every cycle while not halted.
  - ret_cnt increments on each exit from EXEC or BRANCH.
  - Both wrap at 65535.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- cpu_pkg: opcode localparams (OP_NOP..OP_HLT), state encoding (FETCH, DECODE, IMM, BRANCH, WAIT_IN, EXEC, HALT), and instruction field positions.
- One sub-module, cpu_regfile: 4x8 registers, two combinational read ports, one synchronous write port, asynchronous active-low clear.

Test Plan:
- Reset -> pc=0, imem_addr=0, halted=0, all outputs 0.
- Program ADD with r0=5, r1=3 (loaded via IN):
  - Sequence: IN r0; IN r1; ADD r0,r1 (0x11); OUT r0 (0x60).
  - Expected: out_data=8, out_valid high for exactly one cycle, zf=0, cf=0.
- SUB r0,r0 with r0=0x40 -> r0=0, zf=1.
  - Then JZ 0x10 -> next imem_addr=0x10.
  - Repeat with zf=0 -> pc continues at branch address+2.
- ADD 0xFF+0x01 -> r=0x00, zf=1, cf=1.
  - Then MOV -> flags unchanged.
- IN with in_valid held low for 10 cycles -> in_ready high throughout, no state advance.
  - Then in_valid=1 with in_data=0xA5 -> reg[a]=0xA5, in_ready drops the next cycle.
- Branches and HLT:
  - JMP placed at address 0xFF with its target byte at 0x00 -> target fetched from address 0 (wrap).
  - HLT -> halted=1 and imem_addr frozen.
  - reset_n pulsed low mid-EXEC -> clean restart at pc=0.
